// File: rtl/ad7606_pkg.sv
// ad7606_pkg: shared state encoding, header word and default timing for the AD7606 capture path
package ad7606_pkg;
  typedef enum logic [2:0] {IDLE, CONV, WAIT_HI, WAIT_LO, READ, DONE} state_t;
  localparam logic [15:0] HDR_WORD = 16'hA5A5;
  localparam int DEF_CLK_DIV = 4;
  localparam int DEF_CONV_PULSE = 4;
  localparam int DEF_BUSY_TIMEOUT = 2000;
endpackage

// File: rtl/ad7606_serial_rx.sv
// ad7606_serial_rx: SCLK divider, bit counter and 16-bit shifter for the AD7606 DOUTA stream
//   clk, rst      system clock, sync active-high reset
//   enable        high while reading; low parks sclk high and clears the bit state
//   sclk          serial clock, first falls CLK_DIV cycles after enable rises
//   dout_a        serial data, sampled on each sclk rising edge, MSB first
//   word          last completed 16-bit word
//   word_valid    one-cycle pulse on the cycle after the 16th rising edge
module ad7606_serial_rx
  import ad7606_pkg::*;
#(
  parameter int CLK_DIV = DEF_CLK_DIV
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        sclk,
  input  logic        dout_a,
  output logic [15:0] word,
  output logic        word_valid
);
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] sh_q, sh_d, word_q, word_d;
  logic        sclk_q, sclk_d, vld_q, vld_d, tick, rise;
  always_comb begin
    tick   = div_q == 8'(CLK_DIV - 1);
    rise   = enable && tick && !sclk_q;
    div_d  = (!enable || tick) ? 8'd0 : div_q + 8'd1;
    sclk_d = !enable ? 1'b1 : tick ? ~sclk_q : sclk_q;
    sh_d   = !enable ? 16'd0 : rise ? {sh_q[14:0], dout_a} : sh_q;
    bit_d  = !enable ? 4'd0 : rise ? bit_q + 4'd1 : bit_q;
    vld_d  = rise && bit_q == 4'd15;
    word_d = vld_d ? {sh_q[14:0], dout_a} : word_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      div_q  <= '0;
      bit_q  <= '0;
      sh_q   <= '0;
      word_q <= '0;
      sclk_q <= 1'b1;
      vld_q  <= 1'b0;
    end else begin
      div_q  <= div_d;
      bit_q  <= bit_d;
      sh_q   <= sh_d;
      word_q <= word_d;
      sclk_q <= sclk_d;
      vld_q  <= vld_d;
    end
  end
  assign sclk       = sclk_q;
  assign word       = word_q;
  assign word_valid = vld_q;
endmodule

// File: rtl/ad7606_serial_capture.sv
// ad7606_serial_capture: AD7606 conversion sequencer and serial reader feeding the sample FIFO
//   start -> convst pulse -> busy high/low (2-flop synced, timed out) -> cs_n/sclk read of
//   NUM_CH words -> fifo_din/fifo_we_n -> frame_done; overflow and timeout_err are sticky.
//   AD7606_FRAME_HDR_EN: when defined, each frame is preceded by header word 16'hA5A5.
module ad7606_serial_capture
  import ad7606_pkg::*;
#(
  parameter int CLK_DIV      = DEF_CLK_DIV,
  parameter int NUM_CH       = 8,
  parameter int CONV_PULSE   = DEF_CONV_PULSE,
  parameter int BUSY_TIMEOUT = DEF_BUSY_TIMEOUT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        convst,
  input  logic        busy,
  output logic        cs_n,
  output logic        sclk,
  input  logic        dout_a,
  output logic [15:0] fifo_din,
  output logic        fifo_we_n,
  input  logic        fifo_full,
  output logic        frame_done,
  output logic        overflow,
  output logic        timeout_err
);
  state_t      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  ch_q, ch_d;
  logic [1:0]  sync_q;
  logic        ovf_q, tmo_q, tmo, busy_s, vld, hdr, wr_req;
  logic [15:0] word;
  ad7606_serial_rx #(.CLK_DIV(CLK_DIV)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .enable    (state_q == READ),
    .sclk      (sclk),
    .dout_a    (dout_a),
    .word      (word),
    .word_valid(vld)
  );
  assign busy_s = sync_q[1];
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 16'd1;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (start) state_d = CONV;
      end
      CONV:
        if (cnt_q == 16'(CONV_PULSE - 1)) begin
          state_d = WAIT_HI;
          cnt_d   = '0;
        end
      WAIT_HI:
        if (busy_s) begin
          state_d = WAIT_LO;
          cnt_d   = '0;
        end else if (cnt_q == 16'(BUSY_TIMEOUT - 1)) begin
          state_d = DONE;
          tmo     = 1'b1;
        end
      WAIT_LO:
        if (!busy_s) begin
          state_d = READ;
          cnt_d   = '0;
        end else if (cnt_q == 16'(BUSY_TIMEOUT - 1)) begin
          state_d = DONE;
          tmo     = 1'b1;
        end
      READ: begin
        cnt_d = '0;
        if (vld && ch_q == 4'(NUM_CH - 1)) state_d = DONE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end
`ifdef AD7606_FRAME_HDR_EN
  logic hdr_q;
  always_ff @(posedge clk) hdr_q <= !rst && state_d == READ && state_q != READ;
  assign hdr = hdr_q;
`else
  assign hdr = 1'b0;
`endif
  always_comb begin
    wr_req     = vld || hdr;
    ch_d       = state_q != READ ? 4'd0 : vld ? ch_q + 4'd1 : ch_q;
    fifo_din   = hdr ? HDR_WORD : word;
    fifo_we_n  = !(wr_req && !fifo_full);
    convst     = state_q != CONV;
    cs_n       = state_q != READ;
    frame_done = state_q == DONE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ch_q    <= '0;
      sync_q  <= '0;
      ovf_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ch_q    <= ch_d;
      sync_q  <= {sync_q[0], busy};
      ovf_q   <= ovf_q || (wr_req && fifo_full);
      tmo_q   <= tmo_q || tmo;
    end
  end
  assign overflow    = ovf_q;
  assign timeout_err = tmo_q;
endmodule

// File: tb/tb_ad7606_serial_capture.sv
// tb_ad7606_serial_capture: directed self-checking bench for ad7606_serial_capture
module tb_ad7606_serial_capture;
  logic clk = 0, rst = 1, start = 0, busy = 0, dout_a = 0, fifo_full = 0;
  logic convst, cs_n, sclk, fifo_we_n, frame_done, overflow, timeout_err;
  logic [15:0] fifo_din;
  int checks = 0, errors = 0;
  int cyc = 0, bitn = 0, done_n = 0, csf = 0, last_wr = 0;
  logic cs_prev = 1;
  logic [15:0] vals [8];
  logic [15:0] wr_q[$];
  logic [15:0] exp_q[$];

  ad7606_serial_capture dut (
    .clk(clk), .rst(rst), .start(start), .convst(convst), .busy(busy),
    .cs_n(cs_n), .sclk(sclk), .dout_a(dout_a), .fifo_din(fifo_din),
    .fifo_we_n(fifo_we_n), .fifo_full(fifo_full), .frame_done(frame_done),
    .overflow(overflow), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (fifo_we_n === 1'b0) begin
      wr_q.push_back(fifo_din);
      last_wr = cyc;
    end
    if (frame_done === 1'b1) done_n++;
    if (cs_prev === 1'b1 && cs_n === 1'b0) csf = cyc;
    cs_prev = cs_n;
  end

  always @(negedge sclk or posedge cs_n) begin
    logic [15:0] w;
    if (cs_n) bitn = 0;
    else begin
      if (bitn < 128) begin
        w = vals[bitn / 16];
        dout_a = w[15 - (bitn % 16)];
      end
      bitn++;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic begin_frame;
    wr_q.delete();
    done_n = 0;
    start = 1;
    tick();
    start = 0;
    checks++;
    if (convst !== 1'b0) begin
      errors++;
      $display("FAIL convst_low got %b want 0", convst);
    end
    for (int i = 0; i < 20 && convst !== 1'b1; i++) tick();
    repeat (10) tick();
    busy = 1;
    repeat (200) tick();
    busy = 0;
  endtask

  task automatic finish_frame(input int full_ch, input bit extra);
    for (int i = 0; i < 3000 && done_n == 0; i++) begin
      fifo_full = full_ch >= 0 && bitn == 16 * (full_ch + 1);
      start = extra && i < 900 && i % 300 == 150;
      tick();
    end
    fifo_full = 0;
    start = 0;
    repeat (5) tick();
    checks++;
    if (done_n != 1) begin
      errors++;
      $display("FAIL frame_done_count got %0d want 1", done_n);
    end
  endtask

  task automatic check_words(input int skip);
    exp_q.delete();
`ifdef AD7606_FRAME_HDR_EN
    exp_q.push_back(16'hA5A5);
`endif
    for (int k = 0; k < 8; k++) if (k != skip) exp_q.push_back(16'(k + 1));
    checks++;
    if (wr_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL write_count got %0d want %0d", wr_q.size(), exp_q.size());
    end
    for (int k = 0; k < exp_q.size() && k < wr_q.size(); k++) begin
      checks++;
      if (wr_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL word%0d got %h want %h", k, wr_q[k], exp_q[k]);
      end
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) tick();
    checks++;
    if ({convst, cs_n, sclk, fifo_we_n, frame_done, overflow, timeout_err} !== 7'b1111000) begin
      errors++;
      $display("FAIL reset_ctrl got %b want 1111000",
               {convst, cs_n, sclk, fifo_we_n, frame_done, overflow, timeout_err});
    end
    checks++;
    if (fifo_din !== 16'h0000) begin
      errors++;
      $display("FAIL reset_din got %h want 0000", fifo_din);
    end
    rst = 0;
    tick();
  endtask

  task automatic test_basic;
    begin_frame();
    finish_frame(-1, 0);
    check_words(-1);
    checks++;
    if (last_wr - csf != 1024) begin
      errors++;
      $display("FAIL read_latency got %0d want 1024", last_wr - csf);
    end
    checks++;
    if (overflow !== 1'b0 || timeout_err !== 1'b0) begin
      errors++;
      $display("FAIL clean_flags got %b%b want 00", overflow, timeout_err);
    end
  endtask

  task automatic test_overflow;
    begin_frame();
    finish_frame(2, 0);
    check_words(2);
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL overflow got %b want 1", overflow);
    end
  endtask

  task automatic test_timeout;
    int t0, dt;
    wr_q.delete();
    done_n = 0;
    start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 20 && convst !== 1'b1; i++) tick();
    t0 = cyc;
    for (int i = 0; i < 2100 && timeout_err !== 1'b1; i++) tick();
    dt = cyc - t0;
    checks++;
    if (timeout_err !== 1'b1 || dt < 2000 || dt > 2003) begin
      errors++;
      $display("FAIL timeout_time got %0d err %b want 2000..2003 err 1", dt, timeout_err);
    end
    repeat (5) tick();
    checks++;
    if (wr_q.size() != 0 || done_n != 1) begin
      errors++;
      $display("FAIL timeout_frame got writes %0d done %0d want 0 1", wr_q.size(), done_n);
    end
    checks++;
    if ({timeout_err, convst, cs_n} !== 3'b111) begin
      errors++;
      $display("FAIL timeout_idle got %b want 111", {timeout_err, convst, cs_n});
    end
  endtask

  task automatic test_reset_mid;
    int n;
    begin_frame();
    for (int i = 0; i < 2000 && bitn < 4 * 16 + 5; i++) tick();
    rst = 1;
    tick();
    checks++;
    if ({convst, cs_n, sclk, fifo_we_n, overflow, timeout_err} !== 6'b111100) begin
      errors++;
      $display("FAIL mid_reset got %b want 111100",
               {convst, cs_n, sclk, fifo_we_n, overflow, timeout_err});
    end
    rst = 0;
    n = wr_q.size();
    repeat (300) tick();
    checks++;
    if (wr_q.size() != n || cs_n !== 1'b1) begin
      errors++;
      $display("FAIL mid_quiet got %0d cs %b want %0d cs 1", wr_q.size(), cs_n, n);
    end
    begin_frame();
    finish_frame(-1, 0);
    check_words(-1);
  endtask

  task automatic test_extra_start;
    begin_frame();
    finish_frame(-1, 1);
    check_words(-1);
    repeat (50) tick();
    checks++;
    if (convst !== 1'b1 || cs_n !== 1'b1 || done_n != 1) begin
      errors++;
      $display("FAIL extra_start got convst %b cs %b done %0d want 1 1 1", convst, cs_n, done_n);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) vals[i] = 16'(i + 1);
    test_reset();
    test_basic();
    test_overflow();
    test_timeout();
    test_reset_mid();
    test_extra_start();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
